apb_event_collector: RTL and testbench
======================================

Name: apb_event_collector

Overview:
APB completer that sits directly downstream of the event-to-APB requester. It receives write transfers carrying per-source event counts and accumulates them into three running totals (sources A, B, C). Totals saturate, can be read back over APB, and raise sticky threshold interrupts. Programmable wait states on PREADY exercise the requester's wait handling.

Parameters:
WAIT_CYCLES, 1, number of access-phase cycles with apb_pready_o low before completion (0 = zero-wait)
ADDR_A, 32'hABBA0000, register address for source A total
ADDR_B, 32'hBAFF0000, register address for source B total
ADDR_C, 32'hCAFE0000, register address for source C total
THRESH, 32'd100, interrupt threshold applied to each total

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
apb_psel_i  input  1  APB select
apb_penable_i  input  1  APB enable (access phase)
apb_paddr_i  input  32  APB address
apb_pwrite_i  input  1  1 = write, 0 = read
apb_pwdata_i  input  32  write data (event count increment)
apb_pready_o  output  1  transfer complete
apb_prdata_o  output  32  read data
apb_pslverr_o  output  1  error response for unmapped address
total_a_o  output  32  accumulated total, source A
total_b_o  output  32  accumulated total, source B
total_c_o  output  32  accumulated total, source C
irq_o  output  3  sticky threshold flags, bit0 = A, bit1 = B, bit2 = C
irq_clr_i  input  3  per-bit clear pulse for irq_o

Behaviour:
- Reset (asynchronous) forces state IDLE, the wait counter to 0, all totals to 0 and irq_o to 0.
- Combinational outputs during reset are apb_pready_o=0, apb_prdata_o=0, apb_pslverr_o=0.
- FSM states are IDLE and ACCESS.
- IDLE: when psel=1 and penable=0 (setup phase), go to ACCESS and load the wait counter with WAIT_CYCLES. If psel=1 and penable=1 while in IDLE (protocol violation), stay in IDLE and ignore the transfer.
- ACCESS, counter != 0: apb_pready_o=0; decrement the counter each cycle.
- ACCESS, counter == 0: apb_pready_o=1 combinationally. This is the completing cycle. The transfer commits only if psel=1 and penable=1. The next state is IDLE.
- Back-to-back transfers: a setup phase in the cycle after completion is accepted normally from IDLE.
- Abort: if psel drops while in ACCESS, return to IDLE with no commit and no response.
- Latency from the setup cycle to completion is WAIT_CYCLES+1 cycles.
- Address decode uses an exact 32-bit match against ADDR_A, ADDR_B and ADDR_C.
- Unmapped address: in the completing cycle apb_pslverr_o=1 and apb_prdata_o=0; no register changes. pslverr is 0 at all other times.
- Write commit to a mapped address: total_x <= saturate(total_x + pwdata).
  - Compute the sum at 33 bits. If bit32 is set, the result is 32'hFFFFFFFF.
  - A pwdata of 0 is legal and leaves the total unchanged.
- Read: in the completing cycle of a mapped read, apb_prdata_o = total_x. Otherwise apb_prdata_o = 0. Reads have no side effects.
- total_x_o reflect the registered totals; they update the cycle after commit.
- irq_o[x] sets on a committed write where the old total < THRESH and the new total >= THRESH.
  - irq_o[x] stays set until an irq_clr_i[x] pulse, which clears it on the next clock.
  - If a set and a clear occur in the same cycle, set wins.
  - A total already >= THRESH does not re-set the flag after a clear.
- Only one transfer is in flight at a time; there are no outstanding or pipelined transfers.
- Reset asserted mid-transfer aborts it: state returns to IDLE and totals are cleared.

Test Plan:
- WAIT_CYCLES=1, write 5 to ADDR_A: pready low 1 cycle then high; total_a_o becomes 5; irq_o=0; pslverr=0.
- Writes of 60 then 50 to ADDR_B (THRESH=100): after the second, total_b=110 and irq_o[1]=1. Pulse irq_clr_i[1] -> irq_o[1]=0. Write 1 more -> total_b=111, irq_o[1] stays 0.
- Preload total_c to 32'hFFFFFFF0, then write 32'h20: total_c=32'hFFFFFFFF (saturated), no wrap.
- Write to 32'h12340000: pslverr=1 in the completing cycle; all totals unchanged. Read of ADDR_A after writes totalling 7 returns prdata=7 with pslverr=0.
- WAIT_CYCLES=0, back-to-back writes of 1,1,1 to ADDR_A with no idle cycles: each completes in its first access cycle; total_a=3.
- Assert reset during ACCESS of a write of 9 to ADDR_A: no commit; after release, state is IDLE, totals are 0 and pready=0. Also drop psel mid-ACCESS: no commit, return to IDLE.

Source files
------------

// File: rtl/apb_event_collector_if.sv
// apb_event_collector_if
//   APB completer-side bus bundle for apb_event_collector.
//   slave  : used by the collector (select/enable/addr/write/wdata in,
//            ready/rdata/slverr out)
//   master : used by whatever drives the bus (requester or testbench)
interface apb_event_collector_if;
   logic        apb_psel_i;
   logic        apb_penable_i;
   logic [31:0] apb_paddr_i;
   logic        apb_pwrite_i;
   logic [31:0] apb_pwdata_i;
   logic        apb_pready_o;
   logic [31:0] apb_prdata_o;
   logic        apb_pslverr_o;

   modport slave (
      input  apb_psel_i, apb_penable_i, apb_paddr_i, apb_pwrite_i, apb_pwdata_i,
      output apb_pready_o, apb_prdata_o, apb_pslverr_o
   );

   modport master (
      output apb_psel_i, apb_penable_i, apb_paddr_i, apb_pwrite_i, apb_pwdata_i,
      input  apb_pready_o, apb_prdata_o, apb_pslverr_o
   );
endinterface

// File: rtl/apb_event_collector.sv
// apb_event_collector
//   APB completer accumulating per-source event counts into three saturating
//   totals (A, B, C) with sticky threshold interrupts and programmable
//   wait states on PREADY.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   apb            : APB slave bundle (psel/penable/paddr/pwrite/pwdata in,
//                    pready/prdata/pslverr out)
//   total_a/b/c_o  : registered running totals
//   irq_o[2:0]     : sticky threshold flags (bit0=A, bit1=B, bit2=C)
//   irq_clr_i[2:0] : per-bit clear pulse for irq_o
module apb_event_collector #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ADDR_A      = 32'hABBA0000,
   parameter logic [31:0] ADDR_B      = 32'hBAFF0000,
   parameter logic [31:0] ADDR_C      = 32'hCAFE0000,
   parameter logic [31:0] THRESH      = 32'd100
) (
   input  logic                 clk,
   input  logic                 reset,
   apb_event_collector_if.slave apb,
   output logic [31:0]          total_a_o,
   output logic [31:0]          total_b_o,
   output logic [31:0]          total_c_o,
   output logic [2:0]           irq_o,
   input  logic [2:0]           irq_clr_i
);

   localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           hit;
   logic                 mapped;
   logic                 done;
   logic                 commit;
   logic [2:0]           wr_en;
   logic [2:0][31:0]     totals;

   // Exact-match decode, one-hot since the three addresses are distinct.
   assign hit    = {apb.apb_paddr_i == ADDR_C,
                    apb.apb_paddr_i == ADDR_B,
                    apb.apb_paddr_i == ADDR_A};
   assign mapped = |hit;

   // Completing cycle; gated by psel so an aborted transfer never responds.
   assign done   = (state_q == ACCESS) && (cnt_q == '0) && apb.apb_psel_i && !reset;
   assign commit = done && apb.apb_penable_i;
   assign wr_en  = (commit && apb.apb_pwrite_i) ? hit : 3'b000;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            // psel with penable already high is a protocol violation: ignored.
            if (apb.apb_psel_i && !apb.apb_penable_i) begin
               state_d = ACCESS;
               cnt_d   = CW'(WAIT_CYCLES);
            end
         end
         ACCESS: begin
            if (!apb.apb_psel_i)   state_d = IDLE;
            else if (cnt_q != '0)  cnt_d   = cnt_q - CW'(1);
            else                   state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------ response
   always_comb begin
      apb.apb_pready_o  = done;
      apb.apb_pslverr_o = done && !mapped;
      apb.apb_prdata_o  = '0;
      if (done && !apb.apb_pwrite_i) begin
         unique case (1'b1)
            hit[0]:  apb.apb_prdata_o = totals[0];
            hit[1]:  apb.apb_prdata_o = totals[1];
            hit[2]:  apb.apb_prdata_o = totals[2];
            default: apb.apb_prdata_o = '0;
         endcase
      end
   end

   // ------------------------------------------------------ per-source lanes
   for (genvar i = 0; i < 3; i++) begin : g_lane
      logic [31:0] tot_q, tot_d;
      logic        irq_q, irq_d;
      logic [32:0] sum;
      logic [31:0] sat;

      assign sum = {1'b0, tot_q} + {1'b0, apb.apb_pwdata_i};
      assign sat = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

      always_comb begin
         tot_d = tot_q;
         irq_d = irq_q;
         if (irq_clr_i[i]) irq_d = 1'b0;
         if (wr_en[i]) begin
            tot_d = sat;
            // Only an upward crossing sets the flag; set beats clear.
            if ((tot_q < THRESH) && (sat >= THRESH)) irq_d = 1'b1;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            tot_q <= '0;
            irq_q <= 1'b0;
         end else begin
            tot_q <= tot_d;
            irq_q <= irq_d;
         end
      end

      assign totals[i] = tot_q;
      assign irq_o[i]  = irq_q;
   end

   assign total_a_o = totals[0];
   assign total_b_o = totals[1];
   assign total_c_o = totals[2];

endmodule

// File: tb/tb_apb_event_collector.sv
module tb_apb_event_collector;

   localparam logic [31:0] A = 32'hABBA0000;
   localparam logic [31:0] B = 32'hBAFF0000;
   localparam logic [31:0] C = 32'hCAFE0000;
   localparam longint unsigned TH = 100;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // shared bus drive; tgt_r steers psel to DUT0 (WAIT=1) or DUT1 (WAIT=0)
   logic        psel_r, penable_r, pwrite_r, tgt_r;
   logic [31:0] paddr_r, pwdata_r;
   logic [2:0]  clr0, clr1;
   logic [31:0] ta0, tb0, tc0, ta1, tb1, tc1;
   logic [2:0]  irq0, irq1;

   apb_event_collector_if if0 ();
   apb_event_collector_if if1 ();

   assign if0.apb_psel_i    = psel_r & ~tgt_r;
   assign if1.apb_psel_i    = psel_r &  tgt_r;
   assign if0.apb_penable_i = penable_r;
   assign if1.apb_penable_i = penable_r;
   assign if0.apb_paddr_i   = paddr_r;
   assign if1.apb_paddr_i   = paddr_r;
   assign if0.apb_pwrite_i  = pwrite_r;
   assign if1.apb_pwrite_i  = pwrite_r;
   assign if0.apb_pwdata_i  = pwdata_r;
   assign if1.apb_pwdata_i  = pwdata_r;

   apb_event_collector #(.WAIT_CYCLES(1)) dut0 (
      .clk(clk), .reset(reset), .apb(if0),
      .total_a_o(ta0), .total_b_o(tb0), .total_c_o(tc0),
      .irq_o(irq0), .irq_clr_i(clr0));

   apb_event_collector #(.WAIT_CYCLES(0)) dut1 (
      .clk(clk), .reset(reset), .apb(if1),
      .total_a_o(ta1), .total_b_o(tb1), .total_c_o(tc1),
      .irq_o(irq1), .irq_clr_i(clr1));

   typedef struct packed {
      logic [31:0]      prdata;
      logic             pslverr;
      logic [2:0][31:0] tot;
      logic [2:0]       irq;
   } exp_t;

   exp_t q0[$], q1[$];
   int   n_pass = 0, n_tot = 0;

   // reference model: plain per-DUT totals and flags
   longint unsigned mtot[2][3];
   logic [2:0]      mirq[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h @%0t", name, act, req, $time);
   endtask

   function automatic logic rdy(input bit d);
      return d ? if1.apb_pready_o : if0.apb_pready_o;
   endfunction

   function automatic logic [2:0][31:0] tots(input bit d);
      return d ? {tc1, tb1, ta1} : {tc0, tb0, ta0};
   endfunction

   function automatic logic [2:0][31:0] mtots(input bit d);
      return {mtot[d][2][31:0], mtot[d][1][31:0], mtot[d][0][31:0]};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 3; i++) mtot[d][i] = 0;
         mirq[d] = 3'b000;
      end
   endtask

   function automatic int idx_of(input logic [31:0] addr);
      if (addr == A) return 0;
      if (addr == B) return 1;
      if (addr == C) return 2;
      return -1;
   endfunction

   // One complete transfer; expected response pushed at setup time.
   task automatic xfer(input bit d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      int   k = idx_of(addr);
      int   n;
      longint unsigned nw;
      e.pslverr = (k < 0);
      e.prdata  = (!wr && k >= 0) ? mtot[d][k][31:0] : 32'h0;
      if (wr && k >= 0) begin
         nw = mtot[d][k] + longint'(data);
         if (nw > 64'hFFFF_FFFF) nw = 64'hFFFF_FFFF;
         if (mtot[d][k] < TH && nw >= TH) mirq[d][k] = 1'b1;
         mtot[d][k] = nw;
      end
      e.tot = mtots(d);
      e.irq = mirq[d];
      @(negedge clk);
      tgt_r = d; psel_r = 1; penable_r = 0;
      paddr_r = addr; pwrite_r = wr; pwdata_r = data;
      if (d) q1.push_back(e); else q0.push_back(e);
      @(negedge clk);
      penable_r = 1;
      #1;
      n = 0;
      while (!rdy(d) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk(d ? "latency_w0" : "latency_w1", n, d ? 0 : 1);
   endtask

   task automatic idle();
      @(negedge clk);
      psel_r = 0; penable_r = 0;
   endtask

   task automatic clr_irq(input bit d, input logic [2:0] m);
      @(negedge clk);
      if (d) clr1 = m; else clr0 = m;
      @(negedge clk);
      clr0 = 0; clr1 = 0;
      mirq[d] = mirq[d] & ~m;
      #1;
      chk("irq_after_clr", d ? irq1 : irq0, mirq[d]);
   endtask

   // monitor: pops one expectation per completing cycle
   task automatic mon(input bit d);
      exp_t        e;
      logic        pr, se;
      logic [31:0] rd;
      forever begin
         @(negedge clk); #2;
         pr = rdy(d);
         se = d ? if1.apb_pslverr_o : if0.apb_pslverr_o;
         rd = d ? if1.apb_prdata_o  : if0.apb_prdata_o;
         if (!pr) begin
            if (se !== 1'b0) chk("pslverr_idle", se, 0);
         end else if ((d ? q1.size() : q0.size()) == 0) begin
            chk("unexpected_pready", pr, 0);
         end else begin
            e = d ? q1.pop_front() : q0.pop_front();
            chk("prdata", rd, e.prdata);
            chk("pslverr", se, e.pslverr);
            @(posedge clk); #1;
            chk("totals", tots(d), e.tot);
            chk("irq", d ? irq1 : irq0, e.irq);
         end
      end
   endtask

   initial mon(1'b0);
   initial mon(1'b1);

   initial begin
      logic [31:0] a, dt;
      int          w;
      reset = 1; psel_r = 0; penable_r = 0; pwrite_r = 0; tgt_r = 0;
      paddr_r = 0; pwdata_r = 0; clr0 = 0; clr1 = 0;
      model_reset();
      @(negedge clk); #1;
      chk("rst_pready0", if0.apb_pready_o, 0);
      chk("rst_pready1", if1.apb_pready_o, 0);
      chk("rst_prdata0", if0.apb_prdata_o, 0);
      chk("rst_totals0", tots(0), 0);
      chk("rst_totals1", tots(1), 0);
      chk("rst_irq", {irq1, irq0}, 0);
      @(negedge clk); reset = 0;

      // directed plan on DUT0 (WAIT=1)
      xfer(0, 1, A, 5);
      xfer(0, 1, B, 60);
      xfer(0, 1, B, 50); idle();
      clr_irq(0, 3'b010);
      xfer(0, 1, B, 1);
      xfer(0, 1, C, 32'hFFFFFFF0);
      xfer(0, 1, C, 32'h20);
      xfer(0, 1, 32'h12340000, 77);
      xfer(0, 1, A, 2);
      xfer(0, 0, A, 0);
      xfer(0, 0, 32'h12340000, 0);
      xfer(0, 1, A, 0); idle();

      // back-to-back zero-wait on DUT1
      xfer(1, 1, A, 1);
      xfer(1, 1, A, 1);
      xfer(1, 1, A, 1);
      xfer(1, 0, A, 0); idle();
      repeat (2) @(negedge clk);

      // reset in the access phase of a write of 9
      @(negedge clk);
      tgt_r = 0; psel_r = 1; penable_r = 0; paddr_r = A; pwrite_r = 1; pwdata_r = 9;
      @(negedge clk);
      penable_r = 1; reset = 1; #1;
      chk("rst_mid_pready", if0.apb_pready_o, 0);
      @(negedge clk); psel_r = 0; penable_r = 0;
      @(negedge clk); reset = 0;
      model_reset();
      @(negedge clk); #1;
      chk("post_rst_totals0", tots(0), 0);
      chk("post_rst_totals1", tots(1), 0);
      chk("post_rst_irq", {irq1, irq0}, 0);
      chk("post_rst_pready", if0.apb_pready_o, 0);
      xfer(0, 1, A, 4); idle();

      // psel dropped mid-access: no commit, no response
      @(negedge clk);
      tgt_r = 0; psel_r = 1; penable_r = 0; paddr_r = A; pwrite_r = 1; pwdata_r = 50;
      @(negedge clk); psel_r = 0; #1;
      chk("abort_pready0", if0.apb_pready_o, 0);
      @(negedge clk);
      tgt_r = 1; psel_r = 1; penable_r = 0; paddr_r = B; pwrite_r = 1; pwdata_r = 50;
      @(negedge clk); psel_r = 0; #1;
      chk("abort_pready1", if1.apb_pready_o, 0);
      @(negedge clk); #1;
      chk("abort_totals0", tots(0), mtots(0));
      chk("abort_totals1", tots(1), mtots(1));
      xfer(0, 1, A, 3);
      xfer(1, 1, B, 3); idle();

      // randomized traffic over both DUTs
      for (int t = 0; t < 300; t++) begin
         bit d = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: a = A;
            1: a = B;
            2: a = C;
            default: begin
               a = $urandom;
               if (idx_of(a) >= 0) a = a ^ 32'h1;
            end
         endcase
         w = $urandom_range(0, 15);
         dt = (w == 0) ? 32'h0 : (w == 1) ? $urandom : 32'($urandom_range(1, 40));
         xfer(d, 1'($urandom_range(0, 3) != 0), a, dt);
         if ($urandom_range(0, 3) == 0) idle();
         if ($urandom_range(0, 11) == 0) begin
            idle();
            clr_irq(d, 3'($urandom_range(1, 7)));
         end
      end
      idle();

      w = 0;
      while ((q0.size() != 0 || q1.size() != 0) && w < 50) begin
         @(negedge clk); w++;
      end
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
